hazard_scoreboard: RTL and testbench

- Parametrised successor to the decode-stage hazard logic.
- Replaces single-EX-slot rd comparison with a per-register pending-write scoreboard covering integer and FP register files.
- Handles fixed-latency producers (countdown) and variable-latency producers such as the FPU divider or cache-miss loads (explicit writeback release).
- Sits in ID; produces the ID stall and a structural-full flag for the issue logic.

---
 rtl/hazard_scoreboard_pkg.sv | 28 ++
 rtl/hazard_scoreboard_if.sv | 45 ++++
 rtl/hazard_scoreboard_sb_bank.sv | 79 +++++++
 rtl/hazard_scoreboard.sv | 111 +++++++++++
 tb/tb_hazard_scoreboard.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_pkg: shared latency classes and port slots. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hazard_scoreboard_pkg;

  localparam int SB_LAT_VAR     = 0;
  localparam int SB_LAT_W       = 3;

  localparam int SB_LAT_ALU     = 1;
  localparam int SB_LAT_LOAD    = 2;
  localparam int SB_LAT_FP_ADD  = 3;
  localparam int SB_LAT_FP_MADD = 4;
  localparam int SB_LAT_FDIV    = SB_LAT_VAR;
  localparam int SB_LAT_FSQRT   = SB_LAT_VAR;
  localparam int SB_LAT_MISS    = SB_LAT_VAR;

  // Lookup slots into each bank: three sources plus the destination.
  localparam int SB_SLOT_RS1 = 0;
  localparam int SB_SLOT_RS2 = 1;
  localparam int SB_SLOT_RS3 = 2;
  localparam int SB_SLOT_RD  = 3;
  localparam int SB_NPORTS   = 4;

endpackage

`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_if: ID issue, writeback release and stall bundle. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface hazard_scoreboard_if
  import hazard_scoreboard_pkg::*;
#(
  parameter int RW    = 5,
  parameter int LAT_W = SB_LAT_W
) ();

  logic             id_valid;
  logic             id_kill;
  logic [RW-1:0]    id_rs1, id_rs2, id_rs3;
  logic             id_rs1_fp, id_rs2_fp, id_rs3_fp;
  logic             id_rs1_en, id_rs2_en, id_rs3_en;
  logic [RW-1:0]    id_rd;
  logic             id_rd_fp;
  logic             id_rd_en;
  logic [LAT_W-1:0] id_lat;
  logic             wb_valid;
  logic [RW-1:0]    wb_rd;
  logic             wb_fp;
  logic             stall;
  logic             var_full;
  logic [3:0]       var_count;

  modport master (
    output id_valid, id_kill, id_rs1, id_rs2, id_rs3,
           id_rs1_fp, id_rs2_fp, id_rs3_fp, id_rs1_en, id_rs2_en, id_rs3_en,
           id_rd, id_rd_fp, id_rd_en, id_lat, wb_valid, wb_rd, wb_fp,
    input  stall, var_full, var_count
  );

  modport slave (
    input  id_valid, id_kill, id_rs1, id_rs2, id_rs3,
           id_rs1_fp, id_rs2_fp, id_rs3_fp, id_rs1_en, id_rs2_en, id_rs3_en,
           id_rd, id_rd_fp, id_rd_en, id_lat, wb_valid, wb_rd, wb_fp,
    output stall, var_full, var_count
  );

endinterface

`default_nettype wire

// File: rtl/hazard_scoreboard_sb_bank.sv
// ---------------------------------------------------------------------------
// sb_bank: one register bank's pending/variable/countdown state. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sb_bank
  import hazard_scoreboard_pkg::*;
#(
  parameter int NREGS = 32,
  parameter int LAT_W = SB_LAT_W,
  parameter int RW    = $clog2(NREGS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [RW-1:0]        idx_i [SB_NPORTS],
  output logic [SB_NPORTS-1:0] busy_o,
  input  logic                 issue_i,
  input  logic [RW-1:0]        issue_idx_i,
  input  logic [LAT_W-1:0]     issue_lat_i,
  input  logic                 wb_i,
  input  logic [RW-1:0]        wb_idx_i,
  output logic                 rel_o
);

  logic [NREGS-1:0] pend_q, pend_d;
  logic [NREGS-1:0] var_q, var_d;
  logic [LAT_W-1:0] cnt_q [NREGS];
  logic [LAT_W-1:0] cnt_d [NREGS];

  // A fixed entry in its last cycle (cnt==1) is covered by the EX bypass.
  always_comb begin
    for (int k = 0; k < SB_NPORTS; k++) begin
      busy_o[k] = pend_q[idx_i[k]] &
                  (var_q[idx_i[k]] | (cnt_q[idx_i[k]] != LAT_W'(1)));
    end
  end

  assign rel_o = wb_i & pend_q[wb_idx_i] & var_q[wb_idx_i];

  always_comb begin
    pend_d = pend_q;
    var_d  = var_q;
    cnt_d  = cnt_q;
    for (int r = 0; r < NREGS; r++) begin
      if (pend_q[r] && !var_q[r]) begin
        if (cnt_q[r] <= LAT_W'(1)) begin
          pend_d[r] = 1'b0;
          cnt_d[r]  = '0;
        end else begin
          cnt_d[r] = cnt_q[r] - LAT_W'(1);
        end
      end
    end
    if (rel_o) begin
      pend_d[wb_idx_i] = 1'b0;
      var_d[wb_idx_i]  = 1'b0;
    end
    if (issue_i) begin
      pend_d[issue_idx_i] = 1'b1;
      var_d[issue_idx_i]  = (issue_lat_i == LAT_W'(SB_LAT_VAR));
      cnt_d[issue_idx_i]  = issue_lat_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
      var_q  <= '0;
      for (int r = 0; r < NREGS; r++) cnt_q[r] <= '0;
    end else begin
      pend_q <= pend_d;
      var_q  <= var_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard: ID-stage RAW/WAW/structural hazard scoreboard. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_scoreboard
  import hazard_scoreboard_pkg::*;
#(
  parameter int LAT_W   = SB_LAT_W,
  parameter int MAX_VAR = 4,
  parameter int FP_EN   = 1,
  parameter int NREGS   = 32
) (
  input  logic              clk,
  input  logic              rst,
  hazard_scoreboard_if.slave sb
);

  localparam int RW = $clog2(NREGS);

  logic [RW-1:0]        w_idx [SB_NPORTS];
  logic [SB_NPORTS-1:0] w_fp, w_en, w_int_busy, w_fp_busy, w_hit;
  logic                 w_fp_on, w_at_max, w_struct, w_stall, w_issue;
  logic                 w_var_iss, w_wb_fp, w_int_rel, w_fp_rel, w_rel;
  logic [3:0]           var_count_q, var_count_d;
  logic                 var_full_q, var_full_d;

  assign w_fp_on = (FP_EN != 0);

  always_comb begin
    w_idx[SB_SLOT_RS1] = sb.id_rs1;
    w_idx[SB_SLOT_RS2] = sb.id_rs2;
    w_idx[SB_SLOT_RS3] = sb.id_rs3;
    w_idx[SB_SLOT_RD]  = sb.id_rd;
    w_fp = {sb.id_rd_fp, sb.id_rs3_fp, sb.id_rs2_fp, sb.id_rs1_fp} & {SB_NPORTS{w_fp_on}};
    w_en = {sb.id_rd_en, sb.id_rs3_en, sb.id_rs2_en, sb.id_rs1_en};
    for (int k = 0; k < SB_NPORTS; k++) begin
      w_hit[k] = w_en[k] & (w_fp[k] ? w_fp_busy[k] : w_int_busy[k]);
    end
  end

  assign w_at_max  = (var_count_q == 4'(MAX_VAR));
  assign w_struct  = (sb.id_lat == LAT_W'(SB_LAT_VAR)) & sb.id_rd_en & w_at_max;
  assign w_stall   = sb.id_valid & ((|w_hit) | w_struct);
  // Integer x0 is never recorded, so it can never raise a hazard.
  assign w_issue   = sb.id_valid & ~w_stall & ~sb.id_kill & sb.id_rd_en &
                     ~((sb.id_rd == '0) & ~w_fp[SB_SLOT_RD]);
  assign w_var_iss = w_issue & (sb.id_lat == LAT_W'(SB_LAT_VAR));
  assign w_wb_fp   = sb.wb_fp & w_fp_on;

  sb_bank #(.NREGS(NREGS), .LAT_W(LAT_W), .RW(RW)) u_int_bank (
    .clk         (clk),
    .rst         (rst),
    .idx_i       (w_idx),
    .busy_o      (w_int_busy),
    .issue_i     (w_issue & ~w_fp[SB_SLOT_RD]),
    .issue_idx_i (sb.id_rd),
    .issue_lat_i (sb.id_lat),
    .wb_i        (sb.wb_valid & ~w_wb_fp),
    .wb_idx_i    (sb.wb_rd),
    .rel_o       (w_int_rel)
  );

  generate
    if (FP_EN != 0) begin : g_fp
      sb_bank #(.NREGS(NREGS), .LAT_W(LAT_W), .RW(RW)) u_fp_bank (
        .clk         (clk),
        .rst         (rst),
        .idx_i       (w_idx),
        .busy_o      (w_fp_busy),
        .issue_i     (w_issue & w_fp[SB_SLOT_RD]),
        .issue_idx_i (sb.id_rd),
        .issue_lat_i (sb.id_lat),
        .wb_i        (sb.wb_valid & w_wb_fp),
        .wb_idx_i    (sb.wb_rd),
        .rel_o       (w_fp_rel)
      );
    end else begin : g_no_fp
      assign w_fp_busy = '0;
      assign w_fp_rel  = 1'b0;
    end
  endgenerate

  assign w_rel       = w_int_rel | w_fp_rel;
  assign var_count_d = var_count_q + {3'b000, w_var_iss} - {3'b000, w_rel};
  assign var_full_d  = (var_count_d == 4'(MAX_VAR));

  always_ff @(posedge clk) begin
    if (rst) begin
      var_count_q <= '0;
      var_full_q  <= 1'b0;
    end else begin
      var_count_q <= var_count_d;
      var_full_q  <= var_full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(w_var_iss && !w_rel && var_count_q == 4'(MAX_VAR)));
      assert (!(w_rel && !w_var_iss && var_count_q == 4'd0));
    end
  end

  assign sb.stall     = w_stall;
  assign sb.var_full  = var_full_q;
  assign sb.var_count = var_count_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard: directed bench with a ready-time scoreboard model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hazard_scoreboard;

  logic clk;
  logic rst;

  hazard_scoreboard_if #(.RW(5), .LAT_W(3)) sb ();

  hazard_scoreboard #(.LAT_W(3), .MAX_VAR(4), .FP_EN(1), .NREGS(32)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model: a register is busy while the cycle number is below the cycle its
  // fixed result becomes usable, or while a variable write is outstanding.
  int ready_at [2][32];
  bit vpend    [2][32];
  int vcnt;
  int cyc;
  bit started;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic bit m_busy(bit b, logic [4:0] r);
    return vpend[b][r] || (cyc < ready_at[b][r]);
  endfunction

  function automatic bit m_stall();
    bit raw, waw, st;
    raw = (sb.id_rs1_en && m_busy(sb.id_rs1_fp, sb.id_rs1)) ||
          (sb.id_rs2_en && m_busy(sb.id_rs2_fp, sb.id_rs2)) ||
          (sb.id_rs3_en && m_busy(sb.id_rs3_fp, sb.id_rs3));
    waw = sb.id_rd_en && m_busy(sb.id_rd_fp, sb.id_rd);
    st  = (sb.id_lat == 3'd0) && sb.id_rd_en && (vcnt == 4);
    return sb.id_valid && (raw || waw || st);
  endfunction

  always @(posedge clk) begin
    bit st;
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int r = 0; r < 32; r++) begin
          ready_at[b][r] = 0;
          vpend[b][r]    = 1'b0;
        end
      vcnt    = 0;
      started = 1'b1;
    end else begin
      st = m_stall();
      if (sb.wb_valid && vpend[sb.wb_fp][sb.wb_rd]) begin
        vpend[sb.wb_fp][sb.wb_rd] = 1'b0;
        vcnt--;
      end
      if (sb.id_valid && !st && !sb.id_kill && sb.id_rd_en &&
          !(sb.id_rd == 5'd0 && !sb.id_rd_fp)) begin
        if (sb.id_lat == 3'd0) begin
          vpend[sb.id_rd_fp][sb.id_rd] = 1'b1;
          vcnt++;
        end else begin
          ready_at[sb.id_rd_fp][sb.id_rd] = cyc + int'(sb.id_lat);
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      chk("model_stall", int'(sb.stall), int'(m_stall()));
      chk("model_var_count", int'(sb.var_count), vcnt);
      chk("model_var_full", int'(sb.var_full), int'(vcnt == 4));
    end
  end

  task automatic idle();
    sb.id_valid = 0; sb.id_kill = 0;
    sb.id_rs1 = '0; sb.id_rs2 = '0; sb.id_rs3 = '0;
    sb.id_rs1_fp = 0; sb.id_rs2_fp = 0; sb.id_rs3_fp = 0;
    sb.id_rs1_en = 0; sb.id_rs2_en = 0; sb.id_rs3_en = 0;
    sb.id_rd = '0; sb.id_rd_fp = 0; sb.id_rd_en = 0; sb.id_lat = '0;
    sb.wb_valid = 0; sb.wb_rd = '0; sb.wb_fp = 0;
  endtask

  task automatic instr(bit kill, int rd, bit fp, int lat);
    sb.id_valid = 1; sb.id_kill = kill;
    sb.id_rd = 5'(rd); sb.id_rd_fp = fp; sb.id_rd_en = 1; sb.id_lat = 3'(lat);
  endtask

  task automatic rd1(int r, bit fp);
    sb.id_valid = 1; sb.id_rs1 = 5'(r); sb.id_rs1_fp = fp; sb.id_rs1_en = 1;
  endtask

  task automatic rd2(int r, bit fp);
    sb.id_valid = 1; sb.id_rs2 = 5'(r); sb.id_rs2_fp = fp; sb.id_rs2_en = 1;
  endtask

  task automatic wb(int r, bit fp);
    sb.wb_valid = 1; sb.wb_rd = 5'(r); sb.wb_fp = fp;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  initial begin
    cyc = 0; vcnt = 0; started = 0;
    rst = 1;
    idle();
    step(); step();
    rst = 0;
    idle(); neg();
    chk("reset_stall", int'(sb.stall), 0);
    chk("reset_var_count", int'(sb.var_count), 0);
    chk("reset_var_full", int'(sb.var_full), 0);
    step();

    // x5 with latency 3, consumer on the following three cycles
    idle(); instr(0, 5, 0, 3); neg(); chk("x5_issue", int'(sb.stall), 0); step();
    idle(); rd1(5, 0);
    neg(); chk("x5_read_c1", int'(sb.stall), 1); step();
    neg(); chk("x5_read_c2", int'(sb.stall), 1); step();
    neg(); chk("x5_read_c3", int'(sb.stall), 0); step();

    // latency 1 relies on bypass
    idle(); instr(0, 11, 0, 1); step();
    idle(); rd1(11, 0); neg(); chk("lat1_no_stall", int'(sb.stall), 0); step();

    // x0 is never pending, even for a variable-latency write
    idle(); instr(0, 0, 0, 3); step();
    idle(); instr(0, 0, 0, 0); step();
    idle(); rd1(0, 0); neg();
    chk("x0_read", int'(sb.stall), 0);
    chk("x0_var_count", int'(sb.var_count), 0);
    step();

    // variable f2 released by writeback after ten stalled cycles
    idle(); instr(0, 2, 1, 0); step();
    idle(); rd1(2, 1);
    for (int i = 0; i < 10; i++) begin
      if (i == 9) wb(2, 1);
      neg(); chk("f2_var_stall", int'(sb.stall), 1);
      if (i == 0) chk("f2_var_count", int'(sb.var_count), 1);
      step();
    end
    idle(); rd1(2, 1); neg();
    chk("f2_released", int'(sb.stall), 0);
    chk("f2_count_zero", int'(sb.var_count), 0);
    step();

    // fill the variable slots
    for (int i = 1; i <= 4; i++) begin
      idle(); instr(0, i, 1, 0); step();
    end
    idle(); neg();
    chk("full_count", int'(sb.var_count), 4);
    chk("full_flag", int'(sb.var_full), 1);
    step();
    idle(); instr(0, 5, 1, 0); neg(); chk("fifth_var_stall", int'(sb.stall), 1); step();
    idle(); instr(0, 7, 0, 1); neg(); chk("fixed_while_full", int'(sb.stall), 0); step();
    idle(); instr(0, 5, 1, 0); wb(3, 1); neg(); chk("fifth_stall_on_wb", int'(sb.stall), 1); step();
    idle(); instr(0, 5, 1, 0); neg();
    chk("full_clear_after_wb", int'(sb.var_full), 0);
    chk("fifth_issues", int'(sb.stall), 0);
    step();
    idle(); neg(); chk("refilled", int'(sb.var_count), 4); step();
    idle(); wb(3, 1); step();
    idle(); wb(1, 1); step();
    idle(); wb(2, 1); step();
    idle(); wb(4, 1); step();
    idle(); wb(5, 1); step();
    idle(); neg(); chk("drained", int'(sb.var_count), 0); step();

    // writeback to a fixed-latency entry is ignored
    idle(); instr(0, 7, 0, 3); step();
    idle(); wb(7, 0); step();
    idle(); rd1(7, 0); neg();
    chk("wb_fixed_ignored", int'(sb.stall), 1);
    chk("wb_fixed_count", int'(sb.var_count), 0);
    step();
    idle(); step(); step();

    // killed write does not update; kill does not mask a WAW stall
    idle(); instr(0, 9, 0, 2); step();
    idle(); step();
    idle(); instr(1, 9, 0, 2); neg(); chk("kill_no_hazard", int'(sb.stall), 0); step();
    idle(); rd1(9, 0); neg(); chk("kill_no_update", int'(sb.stall), 0); step();
    idle(); instr(0, 9, 0, 2); step();
    idle(); instr(1, 9, 0, 2); neg(); chk("kill_waw_stall", int'(sb.stall), 1); step();

    // reset discards pending state; late writeback ignored
    idle(); instr(0, 4, 0, 0); step();
    idle(); instr(0, 4, 1, 0); step();
    idle(); neg(); chk("pre_reset_count", int'(sb.var_count), 2); step();
    rst = 1; step(); rst = 0;
    idle(); rd1(4, 0); rd2(4, 1); wb(4, 1); neg();
    chk("post_reset_stall", int'(sb.stall), 0);
    chk("post_reset_count", int'(sb.var_count), 0);
    step();
    idle(); neg(); chk("late_wb_ignored", int'(sb.var_count), 0); step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
